// File: rtl/downstream_processor_fsm.sv
// Two-state handshake controller: arms on ack, completes on memwr, counts completions.
// Optional STATE_1 timeout is built only when FSM_TIMEOUT_EN is defined.
module downstream_processor_fsm #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ack,
   input  logic             memwr,
   output logic             out,
   output logic             done,
   output logic             abort,
   output logic             timeout,
   output logic [CNT_W-1:0] txn_count
);

   typedef enum logic {
      IDLE    = 1'b0,
      STATE_1 = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic             out_reg, done_reg, abort_reg, timeout_reg;
   logic             done_next, abort_next, timeout_next;
   logic [CNT_W-1:0] txn_count_reg;
   logic             tmo_hit;

   if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("TIMEOUT out of range 2..65535");
   end

`ifdef FSM_TIMEOUT_EN
   localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);
   logic [15:0] tcnt_reg;

   // Held at zero in IDLE, so it enters STATE_1 already cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tcnt_reg <= '0;
      else if (state_reg == IDLE)
         tcnt_reg <= '0;
      else
         tcnt_reg <= tcnt_reg + 16'd1;
   end

   assign tmo_hit = (tcnt_reg == TLAST);
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // memwr beats ack withdrawal, which beats timeout.
   always_comb begin
      state_next   = state_reg;
      done_next    = 1'b0;
      abort_next   = 1'b0;
      timeout_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ack && !memwr)
               state_next = STATE_1;
         end
         STATE_1: begin
            if (memwr) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else if (!ack) begin
               state_next = IDLE;
               abort_next = 1'b1;
            end else if (tmo_hit) begin
               state_next   = IDLE;
               timeout_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_reg       <= 1'b0;
         done_reg      <= 1'b0;
         abort_reg     <= 1'b0;
         timeout_reg   <= 1'b0;
         txn_count_reg <= '0;
      end else begin
         out_reg     <= (state_next == STATE_1);
         done_reg    <= done_next;
         abort_reg   <= abort_next;
         timeout_reg <= timeout_next;
         if (done_next)
            txn_count_reg <= txn_count_reg + CNT_W'(1);
      end
   end

   assign out       = out_reg;
   assign done      = done_reg;
   assign abort     = abort_reg;
   assign timeout   = timeout_reg;
   assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_downstream_processor_fsm.sv
// Scoreboard bench: stimulus queues the expected outputs per edge, a monitor checks them.
module tb_downstream_processor_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       ack;
   logic       memwr;
   logic       out, done, abort, timeout;
   logic [1:0] txn_count;

   typedef struct packed {
      logic       o;
      logic       d;
      logic       a;
      logic       t;
      logic [1:0] c;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   vec   = 0;

   downstream_processor_fsm #(.CNT_W(2), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .ack(ack), .memwr(memwr),
      .out(out), .done(done), .abort(abort), .timeout(timeout),
      .txn_count(txn_count)
   );

   always #5 clk = ~clk;

   // Monitor: one expected entry per edge, checked 1 ns after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e, a;
         e = exp_q.pop_front();
         a = '{o: out, d: done, a: abort, t: timeout, c: txn_count};
         tests++;
         vec++;
         if (a !== e) begin
            fails++;
            $display("FAIL vec%0d ack/memwr=%b%b: got out=%b done=%b abort=%b tmo=%b cnt=%0d, want out=%b done=%b abort=%b tmo=%b cnt=%0d",
                     vec, ack, memwr, a.o, a.d, a.a, a.t, a.c, e.o, e.d, e.a, e.t, e.c);
         end else begin
            $display("[TB] vec%0d ack=%b memwr=%b out=%b done=%b abort=%b tmo=%b cnt=%0d ok",
                     vec, ack, memwr, a.o, a.d, a.a, a.t, a.c);
         end
      end
   end

   task automatic step(input logic a, input logic m, input logic eo, input logic ed,
                       input logic ea, input logic et, input logic [1:0] ec);
      @(negedge clk);
      ack   = a;
      memwr = m;
      exp_q.push_back('{o: eo, d: ed, a: ea, t: et, c: ec});
      @(posedge clk);
   endtask

   task automatic check_idle(input string name);
      tests++;
      if ({out, done, abort, timeout, txn_count} !== 6'b0) begin
         fails++;
         $display("FAIL %s: got out=%b done=%b abort=%b tmo=%b cnt=%0d, want all 0",
                  name, out, done, abort, timeout, txn_count);
      end else begin
         $display("[TB] %s: all outputs 0 ok", name);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      ack   = 1'b0;
      memwr = 1'b0;
      #12;
      check_idle("reset_state");
      @(negedge clk);
      reset = 1'b0;

      // a  m  out done abort tmo cnt
      step(0, 0, 0, 0, 0, 0, 2'd0);
      step(1, 0, 1, 0, 0, 0, 2'd0);   // arm
      step(1, 1, 0, 1, 0, 0, 2'd1);   // complete
      step(0, 1, 0, 0, 0, 0, 2'd1);   // done lasts one cycle
      step(1, 1, 0, 0, 0, 0, 2'd1);   // memwr blocks arming
      step(1, 0, 1, 0, 0, 0, 2'd1);
      step(0, 0, 0, 0, 1, 0, 2'd1);   // abort
      step(0, 0, 0, 0, 0, 0, 2'd1);
      step(1, 0, 1, 0, 0, 0, 2'd1);
      step(1, 1, 0, 1, 0, 0, 2'd2);
      step(1, 0, 1, 0, 0, 0, 2'd2);   // ack still high re-arms once memwr drops
      step(1, 1, 0, 1, 0, 0, 2'd3);
      step(0, 0, 0, 0, 0, 0, 2'd3);
      step(1, 0, 1, 0, 0, 0, 2'd3);
      step(0, 1, 0, 1, 0, 0, 2'd0);   // memwr beats ack drop; counter wraps
      step(1, 0, 1, 0, 0, 0, 2'd0);
      step(0, 1, 0, 1, 0, 0, 2'd1);
      step(1, 0, 1, 0, 0, 0, 2'd1);

      // Asynchronous reset while armed, between edges.
      #3;
      reset = 1'b1;
      #1;
      check_idle("async_reset_immediate");
      @(posedge clk);
      #1;
      check_idle("reset_held_edge1");
      @(negedge clk);
      ack   = 1'b0;
      memwr = 1'b0;
      @(posedge clk);
      #1;
      check_idle("reset_held_edge2");
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 0, 0, 0, 0, 2'd0);

      // Hold ack with no memwr.
      step(1, 0, 1, 0, 0, 0, 2'd0);
`ifdef FSM_TIMEOUT_EN
      step(1, 0, 1, 0, 0, 0, 2'd0);
      step(1, 0, 1, 0, 0, 0, 2'd0);
      step(1, 0, 1, 0, 0, 0, 2'd0);
      step(1, 0, 0, 0, 0, 1, 2'd0);   // 4th edge after arming
      step(1, 0, 1, 0, 0, 0, 2'd0);   // re-arms from IDLE
      step(0, 0, 0, 0, 1, 0, 2'd0);
`else
      for (int i = 0; i < 22; i++)
         step(1, 0, 1, 0, 0, 0, 2'd0);
      step(0, 0, 0, 0, 1, 0, 2'd0);
`endif
      step(0, 0, 0, 0, 0, 0, 2'd0);

      @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
